cd_pbuf: RTL
============

CD_PBUF -- requirements
Module: cd_pbuf

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8: data word width.
REQ-002 SHALL have parameter A_WIDTH, default 8: word address width per page.
REQ-003 SHALL have parameter N_WIDTH, default 3: page-index width; PAGES = 2**N_WIDTH.
REQ-004 SHALL have parameter F_WIDTH, default 16: per-page flags width.
REQ-005 SHALL have parameter OVERWRITE, default 0: 1 = drop oldest page on full commit, 0 = reject commit.
REQ-006 Ports, exactly these:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- wr_data  in  D_WIDTH  write word
- wr_addr  in  A_WIDTH  write address in writer page
- wr_en  in  1  write strobe
- commit  in  1  hand writer page to reader
- wr_flags  in  F_WIDTH  flags stored on commit
- wr_len  in  A_WIDTH+1  length stored on commit
- commit_fail  out  1  one-cycle pulse, commit rejected
- rd_addr  in  A_WIDTH  read address in reader page
- rd_data  out  D_WIDTH  registered read word
- rd_valid  out  1  reader page holds a committed page
- rd_flags  out  F_WIDTH  flags of reader page
- rd_len  out  A_WIDTH+1  length of reader page
- rd_done  in  1  release reader page
- flush  in  1  discard all pages
- count  out  N_WIDTH  committed pages held
- full  out  1  count == PAGES-1
- drop_cnt  out  8  saturating dropped-page count

Function
REQ-007 Writer always owns exactly one page (wr_sel); at most PAGES-1 pages committed at once.
REQ-008 wr_en SHALL write wr_data to page wr_sel, address wr_addr, at the clock edge, regardless of full.
REQ-009 rd_data SHALL equal word (rd_sel, rd_addr) sampled at the previous edge (1-cycle latency), every cycle, with no read enable.
REQ-010 rd_valid = (count != 0); rd_flags/rd_len = metadata of page rd_sel, combinational from metadata registers; undefined content when rd_valid = 0.
REQ-011 commit when not full: store wr_flags/wr_len for page wr_sel, wr_sel += 1 (wraps mod PAGES), count += 1.
REQ-012 wr_en coincident with commit SHALL write into the page being committed (pre-increment wr_sel).
REQ-013 commit when full, OVERWRITE = 0, no rd_done: no state change; commit_fail = 1 the following cycle.
REQ-014 commit when full, OVERWRITE = 1, no rd_done: commit as REQ-011, rd_sel += 1, count unchanged, drop_cnt += 1 saturating at 255, commit_fail stays 0.
REQ-015 rd_done with count == 0 SHALL be ignored.
REQ-016 rd_done with count != 0: rd_sel += 1 (wraps), count -= 1.
REQ-017 commit and rd_done in the same cycle: both take effect, count unchanged, never fail/drop, including when full.
REQ-018 flush SHALL override commit and rd_done in the same cycle: rd_sel = wr_sel = 0, count = 0, commit_fail = 0; drop_cnt and RAM contents unchanged.
REQ-019 commit_fail SHALL be 0 in every cycle not following a rejected commit.
REQ-020 full SHALL derive combinationally from count.

Reset
REQ-021 reset (sync, high) SHALL set rd_sel = wr_sel = 0, count = 0, full = 0, rd_valid = 0, commit_fail = 0, drop_cnt = 0; rd_data = 0.
REQ-022 reset SHALL NOT clear RAM or metadata; reset mid-write loses uncommitted and committed pages.

Structure
REQ-023 No shared package; PAGES and PAGE_W = N_WIDTH+A_WIDTH SHALL be local parameters.
REQ-024 Storage SHALL be one sub-module cd_pbuf_mem: simple dual-port RAM, 2**PAGE_W x D_WIDTH, address {page, addr}, registered read, no reset.
REQ-025 Metadata (flags, len) SHALL be flip-flop arrays in cd_pbuf.

Verification (D_WIDTH=8, A_WIDTH=4, N_WIDTH=2, F_WIDTH=16)
REQ-026 Write 0xA5 at addr 3, commit flags 0x1234 len 4 -> next cycle rd_valid=1, count=1, rd_flags=0x1234, rd_len=4; rd_addr=3 -> rd_data=0xA5 one cycle later.
REQ-027 OVERWRITE=0: four commits without rd_done -> count=3, full=1, 4th gives commit_fail pulse exactly one cycle; rd_flags still first page.
REQ-028 OVERWRITE=1: commits flags 1,2,3,4 -> count=3, drop_cnt=1, rd_flags=2; 300 further commits -> drop_cnt=255.
REQ-029 Full, commit + rd_done same cycle -> count stays 3, no commit_fail, rd_flags advances to next page.
REQ-030 count=2, flush + commit + rd_done same cycle -> count=0, rd_valid=0, wr_sel=rd_sel=0, no commit_fail; rd_done when empty -> no change.
REQ-031 Ring wrap: 10 commit/rd_done pairs with distinct data -> each page read back correct, reset mid-sequence -> all outputs per REQ-021.

Source files
------------

// File: rtl/cd_pbuf_mem.sv
// Page storage for cd_pbuf: simple dual-port RAM with registered read.
// Read-during-write to the same word returns the old contents.
module cd_pbuf_mem #(
  parameter int D_WIDTH = 8,
  parameter int ADDR_W  = 11
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] r_mem [2**ADDR_W];
  logic [D_WIDTH-1:0] r_q_p1;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    r_q_p1 <= r_mem[rd_addr];
  end

  assign rd_data = r_q_p1;

endmodule

// File: rtl/cd_pbuf.sv
// Paged ring buffer: the writer fills one page and commits it with metadata;
// the reader walks committed pages in order and releases them with rd_done.
module cd_pbuf #(
  parameter int D_WIDTH   = 8,
  parameter int A_WIDTH   = 8,
  parameter int N_WIDTH   = 3,
  parameter int F_WIDTH   = 16,
  parameter int OVERWRITE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic               wr_en,
  input  logic               commit,
  input  logic [F_WIDTH-1:0] wr_flags,
  input  logic [A_WIDTH:0]   wr_len,
  output logic               commit_fail,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               rd_valid,
  output logic [F_WIDTH-1:0] rd_flags,
  output logic [A_WIDTH:0]   rd_len,
  input  logic               rd_done,
  input  logic               flush,
  output logic [N_WIDTH-1:0] count,
  output logic               full,
  output logic [7:0]         drop_cnt
);

  localparam int PAGES  = 2**N_WIDTH;
  localparam int PAGE_W = N_WIDTH + A_WIDTH;

  logic [N_WIDTH-1:0] r_wr_sel;
  logic [N_WIDTH-1:0] r_rd_sel;
  logic [N_WIDTH-1:0] r_count;
  logic               r_fail;
  logic [7:0]         r_drop;
  logic               r_rd_clr;
  logic [F_WIDTH-1:0] r_flags [PAGES];
  logic [A_WIDTH:0]   r_len   [PAGES];

  logic               w_full;
  logic               w_live;
  logic               w_done;
  logic               w_blocked;
  logic               w_accept;
  logic               w_drop;
  logic               w_reject;
  logic [D_WIDTH-1:0] w_mem_q;

  assign w_full    = (r_count == N_WIDTH'(PAGES - 1));
  assign w_live    = !reset && !flush;
  assign w_done    = w_live && rd_done && (r_count != '0);
  // A commit only collides with a full ring when no release frees a slot.
  assign w_blocked = commit && w_live && w_full && !w_done;
  assign w_accept  = commit && w_live && (!w_blocked || (OVERWRITE != 0));
  assign w_drop    = w_blocked && (OVERWRITE != 0);
  assign w_reject  = w_blocked && (OVERWRITE == 0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_sel <= '0;
      r_rd_sel <= '0;
      r_count  <= '0;
      r_fail   <= 1'b0;
      r_drop   <= '0;
      r_rd_clr <= 1'b1;
    end else begin
      r_rd_clr <= 1'b0;
      r_fail   <= w_reject;
      if (flush) begin
        r_wr_sel <= '0;
        r_rd_sel <= '0;
        r_count  <= '0;
      end else begin
        if (w_accept) r_wr_sel <= r_wr_sel + 1'b1;
        if (w_done || w_drop) r_rd_sel <= r_rd_sel + 1'b1;
        if (w_accept && !w_done && !w_drop) r_count <= r_count + 1'b1;
        else if (w_done && !w_accept) r_count <= r_count - 1'b1;
        if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_flags[r_wr_sel] <= wr_flags;
      r_len[r_wr_sel]   <= wr_len;
    end
  end

  cd_pbuf_mem #(
    .D_WIDTH (D_WIDTH),
    .ADDR_W  (PAGE_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({r_wr_sel, wr_addr}),
    .wr_data (wr_data),
    .rd_addr ({r_rd_sel, rd_addr}),
    .rd_data (w_mem_q)
  );

  // Read stage p1: the RAM register itself has no reset, so mask it after reset.
  assign rd_data     = r_rd_clr ? '0 : w_mem_q;
  assign rd_valid    = (r_count != '0);
  assign rd_flags    = r_flags[r_rd_sel];
  assign rd_len      = r_len[r_rd_sel];
  assign count       = r_count;
  assign full        = w_full;
  assign commit_fail = r_fail;
  assign drop_cnt    = r_drop;

endmodule
